ultrasound_ping_sequencer: RTL and testbench

Drives one ultrasonic ranging cycle: trigger pulse, wait for echo, measure echo width in 75us ticks, then hold off before the next ping.
- Sits directly upstream of the programmable 75us timer. Its timer_start/timer_length outputs drive that timer; it consumes the timer's expired output for trigger width, echo timeout and inter-ping holdoff.
- Result feeds the distance/position logic downstream.

---
 rtl/ultrasound_ping_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_ultrasound_ping_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ultrasound_ping_sequencer.sv
// ultrasound_ping_sequencer
//   Runs one ultrasonic ranging cycle per start request:
//   trigger pulse -> wait for echo -> measure echo width in timer ticks
//   -> quiet holdoff. Interval timing (trigger width, echo timeout,
//   holdoff) comes from an external programmable timer driven through
//   timer_start/timer_length and observed on timer_expired.
//
//   Ports
//     clk           in   system clock
//     reset         in   asynchronous, active-high reset
//     start         in   request one ping (sampled only when idle)
//     echo_in       in   raw sensor echo, asynchronous to clk
//     timer_expired in   expired level from the external timer
//     timer_start   out  one-cycle start pulse to the external timer
//     timer_length  out  interval count for the external timer (10 bits)
//     trigger       out  sensor trigger pin
//     echo_ticks    out  last echo width in ticks, 1023 on timeout
//     valid         out  one-cycle pulse when echo_ticks/timeout update
//     timeout       out  1 = last result had no complete echo
//     busy          out  high whenever a ping is in progress
//
//   Build option
//     ECHO_FILTER_EN : when defined, the synchronized echo only changes
//     level after 4 consecutive identical samples (glitch rejection,
//     edge latency 6 cycles instead of 2).
module ultrasound_ping_sequencer #(
  parameter int COUNT_GOAL  = 2024,
  parameter int TRIGGER_LEN = 1,
  parameter int TIMEOUT_LEN = 500,
  parameter int HOLDOFF_LEN = 800
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       echo_in,
  input  logic       timer_expired,
  output logic       timer_start,
  output logic [9:0] timer_length,
  output logic       trigger,
  output logic [9:0] echo_ticks,
  output logic       valid,
  output logic       timeout,
  output logic       busy
);

  localparam int         DIV_W     = (COUNT_GOAL > 1) ? $clog2(COUNT_GOAL) : 1;
  localparam logic [9:0] TICKS_MAX = 10'd1023;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE,
    S_HOLDOFF
  } state_t;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == TICKS_MAX) ? v : v + 10'd1;
  endfunction

  state_t             state_q, state_d;
  logic               trigger_q, trigger_d;
  logic               tstart_q, tstart_d;
  logic [9:0]         tlen_q, tlen_d;
  logic [9:0]         ticks_q, ticks_d;
  logic               valid_q, valid_d;
  logic               tout_q, tout_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [9:0]         width_q, width_d;
  logic               sync1_q, sync2_q, echo_prev_q;
  logic               echo_lvl, echo_rise, echo_fall, exp_ok, to_holdoff;

  // Echo synchronizer; echo_prev_q is the edge-detect history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      echo_prev_q <= 1'b0;
    end else begin
      sync1_q     <= echo_in;
      sync2_q     <= sync1_q;
      echo_prev_q <= echo_lvl;
    end
  end

`ifdef ECHO_FILTER_EN
  logic       filt_q, filt_d;
  logic [1:0] fcnt_q, fcnt_d;

  // fcnt counts consecutive samples disagreeing with the filtered level;
  // the fourth disagreeing sample flips the level.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = 2'd0;
    if (sync2_q != filt_q) begin
      if (fcnt_q == 2'd3) filt_d = sync2_q;
      else                fcnt_d = fcnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_q <= 1'b0;
      fcnt_q <= 2'd0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign echo_lvl = filt_q;
`else
  assign echo_lvl = sync2_q;
`endif

  assign echo_rise = echo_lvl & ~echo_prev_q;
  assign echo_fall = ~echo_lvl & echo_prev_q;
  // While our start pulse is in flight the timer still shows the previous
  // interval's expired level.
  assign exp_ok    = timer_expired & ~tstart_q;

  always_comb begin
    state_d    = state_q;
    tstart_d   = 1'b0;
    tlen_d     = tlen_q;
    ticks_d    = ticks_q;
    valid_d    = 1'b0;
    tout_d     = tout_q;
    div_d      = div_q;
    width_d    = width_q;
    to_holdoff = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_TRIG;
          tstart_d = 1'b1;
          tlen_d   = 10'(TRIGGER_LEN);
        end
      end
      S_TRIG: begin
        if (exp_ok) begin
          state_d  = S_WAIT_RISE;
          tstart_d = 1'b1;
          tlen_d   = 10'(TIMEOUT_LEN);
        end
      end
      S_WAIT_RISE: begin
        if (exp_ok) begin
          ticks_d    = TICKS_MAX;
          tout_d     = 1'b1;
          to_holdoff = 1'b1;
        end else if (echo_rise) begin
          state_d = S_MEASURE;
          div_d   = '0;
          width_d = 10'd0;
        end
      end
      S_MEASURE: begin
        // A falling edge takes priority over a simultaneous timeout.
        if (echo_fall) begin
          ticks_d    = width_q;
          tout_d     = 1'b0;
          to_holdoff = 1'b1;
        end else if (exp_ok) begin
          ticks_d    = TICKS_MAX;
          tout_d     = 1'b1;
          to_holdoff = 1'b1;
        end else if (div_q == DIV_W'(COUNT_GOAL - 1)) begin
          div_d   = '0;
          width_d = sat_inc(width_q);
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_HOLDOFF: begin
        if (exp_ok) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (to_holdoff) begin
      state_d  = S_HOLDOFF;
      tstart_d = 1'b1;
      tlen_d   = 10'(HOLDOFF_LEN);
      valid_d  = 1'b1;
    end
  end

  assign trigger_d = (state_d == S_TRIG);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      trigger_q <= 1'b0;
      tstart_q  <= 1'b0;
      tlen_q    <= 10'd0;
      ticks_q   <= 10'd0;
      valid_q   <= 1'b0;
      tout_q    <= 1'b0;
      div_q     <= '0;
      width_q   <= 10'd0;
    end else begin
      state_q   <= state_d;
      trigger_q <= trigger_d;
      tstart_q  <= tstart_d;
      tlen_q    <= tlen_d;
      ticks_q   <= ticks_d;
      valid_q   <= valid_d;
      tout_q    <= tout_d;
      div_q     <= div_d;
      width_q   <= width_d;
    end
  end

  assign timer_start  = tstart_q;
  assign timer_length = tlen_q;
  assign trigger      = trigger_q;
  assign echo_ticks   = ticks_q;
  assign valid        = valid_q;
  assign timeout      = tout_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_ultrasound_ping_sequencer.sv
// Bench for ultrasound_ping_sequencer with a behavioural interval timer.
module tb_ultrasound_ping_sequencer;
  localparam int CG       = 4;
  localparam int TRIG_LEN = 1;
  localparam int TO_LEN   = 50;
  localparam int HO_LEN   = 10;
`ifdef ECHO_FILTER_EN
  localparam int EDGE_LAT = 6;
`else
  localparam int EDGE_LAT = 2;
`endif
  // Latest echo drop (clocks after trigger fall) that still beats the timeout.
  localparam int FALL_LAST = TO_LEN * CG + 1 - EDGE_LAT;

  logic       clk = 1'b0;
  logic       reset, start, echo_in;
  logic       timer_expired = 1'b0;
  logic       timer_start, trigger, valid, timeout, busy;
  logic [9:0] timer_length, echo_ticks;
  int         n_chk = 0;
  int         n_pass = 0;
  int         rem = 0;

  always #5 clk = ~clk;

  ultrasound_ping_sequencer #(
    .COUNT_GOAL (CG),
    .TRIGGER_LEN(TRIG_LEN),
    .TIMEOUT_LEN(TO_LEN),
    .HOLDOFF_LEN(HO_LEN)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .echo_in      (echo_in),
    .timer_expired(timer_expired),
    .timer_start  (timer_start),
    .timer_length (timer_length),
    .trigger      (trigger),
    .echo_ticks   (echo_ticks),
    .valid        (valid),
    .timeout      (timeout),
    .busy         (busy)
  );

  // Interval timer model: expired rises length*CG clocks after start and
  // stays high until the next start. Not affected by the sequencer reset.
  always @(posedge clk) begin
    if (timer_start) begin
      rem           <= int'(timer_length) * CG;
      timer_expired <= 1'b0;
    end else if (rem > 1) begin
      rem <= rem - 1;
    end else if (rem == 1) begin
      rem           <= 0;
      timer_expired <= 1'b1;
    end
  end

  task automatic check(input string tag, input int act, input int exp, input int tol);
    n_chk++;
    if (act >= exp - tol && act <= exp + tol) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (+/-%0d)", tag, act, exp, tol);
  endtask

  // One ping. Echo high for clocks [d, d+w) after trigger fall (d<0: none,
  // w<0: never falls); gd>=0 adds a 2-clock glitch at gd; spam holds start
  // high while busy; rst_k>=0 resets the DUT at that clock after trigger fall.
  task automatic ping(input int d, input int w, input int gd, input bit spam, input int rst_k);
    int  t_rise, t_fall, t_valid, t_idle, k, nvalid, nrise, got_ticks, got_to, act, exp_ticks;
    bit  fell, prev_trig, done, e, exp_to;
    t_rise = 0; t_fall = 0; t_valid = 0; t_idle = 0; nvalid = 0; nrise = 0;
    got_ticks = 0; got_to = 0; fell = 0; prev_trig = 0; done = 0;
    start = 1'b1;
    for (int cyc = 1; cyc <= 3000 && !done; cyc++) begin
      @(negedge clk);
      if (trigger && !prev_trig) begin nrise++; t_rise = cyc; end
      if (!trigger && prev_trig && !fell) begin fell = 1; t_fall = cyc; end
      prev_trig = trigger;
      if (valid) begin
        nvalid++;
        if (nvalid == 1) begin t_valid = cyc; got_ticks = echo_ticks; got_to = timeout; end
      end
      k = fell ? cyc - t_fall : -1;
      e = 0;
      if (nvalid == 0 && k >= 0) begin
        if (d >= 0 && k >= d && (w < 0 || k < d + w)) e = 1;
        if (gd >= 0 && k >= gd && k < gd + 2) e = 1;
      end
      echo_in = e;
      start   = spam ? (nvalid == 0 || busy) : 1'b0;
      if (nvalid > 0 && !busy) begin done = 1; t_idle = cyc; end
      if (rst_k >= 0 && k == rst_k) begin
        reset = 1'b1;
        #1;
        check("rst_trigger", trigger, 0, 0);
        check("rst_busy", busy, 0, 0);
        check("rst_valid", valid, 0, 0);
        check("rst_ticks", echo_ticks, 0, 0);
        @(negedge clk);
        reset = 1'b0; echo_in = 1'b0; start = 1'b0;
        act = 0;
        repeat (260) begin
          @(negedge clk);
          if (valid || busy || trigger) act++;
        end
        check("rst_quiet", act, 0, 0);
        return;
      end
    end
    if (!done) begin
      check("ping_done", 0, 1, 0);
      start = 1'b0; echo_in = 1'b0;
      return;
    end
    exp_to    = (d < 0) || (w < 0) || (d + w > FALL_LAST);
    exp_ticks = exp_to ? 1023 : w / CG;
    check("trig_pulses", nrise, 1, 0);
    check("trig_len", t_fall - t_rise, TRIG_LEN * CG + 2, 2);
    check("valid_cnt", nvalid, 1, 0);
    check("timeout", got_to, int'(exp_to), 0);
    check("echo_ticks", got_ticks, exp_ticks, exp_to ? 0 : 1);
    if (exp_to) check("to_latency", t_valid - t_fall, TO_LEN * CG + 2, 3);
    check("holdoff", t_idle - t_valid, HO_LEN * CG + 2, 3);
  endtask

  initial begin
    int act;
    reset = 1'b1; start = 1'b0; echo_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_trigger0", trigger, 0, 0);
    check("rst_tstart0", timer_start, 0, 0);
    check("rst_tlen0", timer_length, 0, 0);
    check("rst_ticks0", echo_ticks, 0, 0);
    check("rst_valid0", valid, 0, 0);
    check("rst_timeout0", timeout, 0, 0);
    check("rst_busy0", busy, 0, 0);
    reset = 1'b0;
    @(negedge clk);

    ping(20, 40, -1, 0, -1);           // normal echo
    ping(-1, 0, -1, 0, -1);            // no echo
    ping(20, -1, -1, 0, -1);           // echo stuck high
    for (int i = 0; i < 6; i++)
      ping(int'($urandom_range(3, 40)), int'($urandom_range(8, 120)), -1,
           1'($urandom_range(0, 1)), -1);
    ping(15, 300, -1, 0, -1);          // echo outlasts the timeout
    ping(20, 40, -1, 1, -1);           // start held high throughout
    ping(20, 40, -1, 0, 30);           // reset mid-measure

    // Reset while the trigger is high.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("trig_high", trigger, 1, 0);
    reset = 1'b1;
    #1;
    check("rst_trig_drop", trigger, 0, 0);
    check("rst_trig_busy", busy, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    act = 0;
    repeat (20) begin
      @(negedge clk);
      if (valid || busy || trigger) act++;
    end
    check("rst_trig_quiet", act, 0, 0);

    ping(20, 40, -1, 0, -1);                // clean ping after reset
    ping(20, FALL_LAST - 20, -1, 0, -1);    // fall lands on timer expiry
    ping(20, FALL_LAST - 19, -1, 0, -1);    // fall one clock too late
`ifdef ECHO_FILTER_EN
    ping(30, 40, 10, 0, -1);                // short glitch before the echo
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
